// File: rtl/wb_master_seq.sv
// Wishbone B4 classic single-transfer master with bounded retry and idle gap.
// Define WB_MASTER_TIMEOUT_EN to abort ACTIVE cycles after TIMEOUT clocks.
module wb_master_seq #(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int IDLE_GAP  = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADR_W-1:0]   req_adr_i,
  input  logic [DAT_W-1:0]   req_dat_i,
  input  logic [DAT_W/8-1:0] req_sel_i,
  output logic               rsp_valid_o,
  output logic [DAT_W-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               rsp_rty_o,
  output logic               rsp_tmo_o,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  output logic [ADR_W-1:0]   adr_o,
  output logic [DAT_W-1:0]   dat_o,
  output logic [DAT_W/8-1:0] sel_o,
  input  logic [DAT_W-1:0]   dat_i,
  input  logic               ack_i,
  input  logic               err_i,
  input  logic               rty_i
);
  localparam int SEL_W = DAT_W / 8;
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_LAST_I = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESP, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [RTY_W-1:0]   rcnt_q, rcnt_d;
  logic               reiss_q, reiss_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic               err_q, err_d;
  logic               rty_q, rty_d;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0]   tcnt_q, tcnt_d;
  logic               tmo_q, tmo_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      rcnt_q  <= '0;
      reiss_q <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rcnt_q  <= rcnt_d;
      reiss_q <= reiss_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rcnt_d  = rcnt_q;
    reiss_d = reiss_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    rty_d   = rty_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
          rcnt_d  = '0;
          reiss_d = 1'b0;
          rdat_d  = '0;
          err_d   = 1'b0;
          rty_d   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
          tcnt_d  = '0;
          tmo_d   = 1'b0;
`endif
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
`ifdef WB_MASTER_TIMEOUT_EN
        tcnt_d = tcnt_q + 1'b1;
`endif
        if (err_i) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (rty_i) begin
          if (rcnt_q != RTY_MAX) begin
            rcnt_d  = rcnt_q + 1'b1;
            reiss_d = 1'b1;
            gap_d   = '0;
            state_d = (IDLE_GAP == 0) ? S_ACTIVE : S_GAP;
`ifdef WB_MASTER_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            rty_d   = 1'b1;
            state_d = S_RESP;
          end
        end else if (ack_i) begin
          if (!we_q) rdat_d = dat_i;
          state_d = S_RESP;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        reiss_d = 1'b0;
        gap_d   = '0;
        state_d = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = reiss_q ? S_ACTIVE : S_IDLE;
          reiss_d = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields read as zero outside ACTIVE so idle cycles are clean.
  logic act, resp;
  assign act  = (state_q == S_ACTIVE);
  assign resp = (state_q == S_RESP);

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign cyc_o       = act;
  assign stb_o       = act;
  assign we_o        = act && we_q;
  assign adr_o       = act ? adr_q : '0;
  assign dat_o       = act ? dat_q : '0;
  assign sel_o       = act ? sel_q : '0;
  assign rsp_valid_o = resp;
  assign rsp_dat_o   = resp ? rdat_q : '0;
  assign rsp_err_o   = resp && err_q;
  assign rsp_rty_o   = resp && rty_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_tmo_o   = resp && tmo_q;
`else
  assign rsp_tmo_o   = 1'b0;
`endif
endmodule
